cordic_engine: RTL and testbench

CORDIC_ENGINE -- requirements
Module: cordic_engine

---
 rtl/cordic_engine.sv | 192 +++++++++++++++++++
 tb/tb_cordic_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
// cordic_engine: iterative rotation-mode CORDIC that returns cos(angle).
// The input angle is IEEE-754 single precision in radians. It is converted
// to signed Q2.30 and then rotated for 32 iterations, one iteration per clock.
// Optional feature: define CORDIC_SINE_OUT_EN to add the `sine` output port,
// which carries the final y of the rotation.

module cordic_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] theta,
  output logic        range_err
`ifdef CORDIC_SINE_OUT_EN
  ,
  output logic [31:0] sine
`endif
);

  // Initial x value. The gain of the 32-stage rotation chain is compensated
  // up front, so x finishes at cos(angle) with no final multiply.
  localparam logic signed [31:0] CORDIC_GAIN = 32'sh26DD3B80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH,
    S_REJECT
  } state_t;

  state_t             state;
  logic signed [31:0] x_q;
  logic signed [31:0] y_q;
  logic signed [31:0] w_q;
  logic signed [31:0] target_q;
  logic        [4:0]  iter_q;

  // round(atan(2^-i) * 2^30) for i = 0..31
  // NOTE: this is a constant function and synthesises to pure logic. It holds
  // no storage, so it is neither reset nor written.
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 32'h3243F6A9;
      5'd1:    atan_lut = 32'h1DAC6705;
      5'd2:    atan_lut = 32'h0FADBAFD;
      5'd3:    atan_lut = 32'h07F56EA7;
      5'd4:    atan_lut = 32'h03FEAB77;
      5'd5:    atan_lut = 32'h01FFD55C;
      5'd6:    atan_lut = 32'h00FFFAAB;
      5'd7:    atan_lut = 32'h007FFF55;
      5'd8:    atan_lut = 32'h003FFFEB;
      5'd9:    atan_lut = 32'h001FFFFD;
      5'd10:   atan_lut = 32'h00100000;
      5'd11:   atan_lut = 32'h00080000;
      5'd12:   atan_lut = 32'h00040000;
      5'd13:   atan_lut = 32'h00020000;
      5'd14:   atan_lut = 32'h00010000;
      5'd15:   atan_lut = 32'h00008000;
      5'd16:   atan_lut = 32'h00004000;
      5'd17:   atan_lut = 32'h00002000;
      5'd18:   atan_lut = 32'h00001000;
      5'd19:   atan_lut = 32'h00000800;
      5'd20:   atan_lut = 32'h00000400;
      5'd21:   atan_lut = 32'h00000200;
      5'd22:   atan_lut = 32'h00000100;
      5'd23:   atan_lut = 32'h00000080;
      5'd24:   atan_lut = 32'h00000040;
      5'd25:   atan_lut = 32'h00000020;
      5'd26:   atan_lut = 32'h00000010;
      5'd27:   atan_lut = 32'h00000008;
      5'd28:   atan_lut = 32'h00000004;
      5'd29:   atan_lut = 32'h00000002;
      5'd30:   atan_lut = 32'h00000001;
      default: atan_lut = 32'h00000000;
    endcase
  endfunction

  logic [7:0]  exp_f;
  logic [31:0] mag;
  logic [31:0] target_in;
  logic        in_range_err;

  assign exp_f = angle[30:23];

  // Unpack the float into Q2.30. Any exponent with bit 7 set is out of range
  // (|angle| >= 2.0, Inf or NaN).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    mag          = '0;
    in_range_err = exp_f[7];
    if (exp_f != 8'd0 && !exp_f[7]) begin
      // The Q2.30 value is {1,mant} * 2^(exp-120). Right shifts truncate toward zero.
      if (exp_f >= 8'd120) mag = {8'd0, 1'b1, angle[22:0]} << (exp_f - 8'd120);
      else                 mag = {8'd0, 1'b1, angle[22:0]} >> (8'd120 - exp_f);
    end
    target_in = angle[31] ? -mag : mag;
  end

  logic signed [31:0] x_sh;
  logic signed [31:0] y_sh;
  logic signed [31:0] atan_i;
  logic               dir_pos;
  logic signed [31:0] x_nx;
  logic signed [31:0] y_nx;
  logic signed [31:0] w_nx;

  // One rotation step. It rotates toward the target and wraps at 32 bits.
  always_comb begin
    x_sh    = x_q >>> iter_q;
    y_sh    = y_q >>> iter_q;
    atan_i  = $signed(atan_lut(iter_q));
    dir_pos = (w_q <= target_q);
    x_nx    = dir_pos ? (x_q - y_sh)   : (x_q + y_sh);
    y_nx    = dir_pos ? (y_q + x_sh)   : (y_q - x_sh);
    w_nx    = dir_pos ? (w_q + atan_i) : (w_q - atan_i);
  end

  // Control FSM and datapath registers. The outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      theta     <= '0;
      range_err <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      target_q  <= '0;
      iter_q    <= '0;
`ifdef CORDIC_SINE_OUT_EN
      sine      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (in_range_err) begin
              range_err <= 1'b1;
              result    <= '0;
              theta     <= '0;
`ifdef CORDIC_SINE_OUT_EN
              sine      <= '0;
`endif
              state     <= S_REJECT;
            end else begin
              range_err <= 1'b0;
              target_q  <= $signed(target_in);
              x_q       <= CORDIC_GAIN;
              y_q       <= '0;
              w_q       <= '0;
              iter_q    <= '0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          w_q    <= w_nx;
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'd31) state <= S_FINISH;
        end
        S_FINISH: begin
          result <= x_q;
          theta  <= w_q;
`ifdef CORDIC_SINE_OUT_EN
          sine   <= y_q;
`endif
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        S_REJECT: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed bench for cordic_engine. The expected values
// are computed by hand in Q2.30.

module tb_cordic_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] angle;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] theta;
  logic        range_err;
`ifdef CORDIC_SINE_OUT_EN
  logic [31:0] sine;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cordic_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .angle     (angle),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .theta     (theta),
    .range_err (range_err)
`ifdef CORDIC_SINE_OUT_EN
    ,
    .sine      (sine)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input int tol);
    longint diff;
    logic   ok;
    diff = longint'($signed(obs)) - longint'($signed(exp));
    ok   = (diff <= tol) && (diff >= -tol);
    n_checks++;
    assert (ok === 1'b1)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Pulse start for one cycle, then return the number of edges until done
  // is seen (0 if done is not seen within the budget).
  task automatic run(input logic [31:0] a, output int edges);
    @(negedge clk);
    angle = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  localparam logic [31:0] F_ZERO   = 32'h00000000;
  localparam logic [31:0] F_PI3    = 32'h3F860A92;
  localparam logic [31:0] F_NPI3   = 32'hBF860A92;
  localparam logic [31:0] F_HALF   = 32'h3F000000;
  localparam logic [31:0] F_2P5    = 32'h40200000;
  localparam logic [31:0] F_NAN    = 32'h7FC00000;
  localparam logic [31:0] F_NEG2   = 32'hC0000000;
  localparam logic [31:0] F_BELOW2 = 32'h3FFFFFFF;
  localparam logic [31:0] F_DENORM = 32'h00000001;

  // float(pi/3) unpacks exactly to 0x43054900 in Q2.30.
  localparam logic [31:0] Q_PI3    = 32'h43054900;
  localparam logic [31:0] Q_NPI3   = 32'hBCFAB700;
  localparam logic [31:0] Q_ONE    = 32'h40000000;
  localparam logic [31:0] Q_HALF   = 32'h20000000;
  localparam logic [31:0] Q_COS05  = 32'd942297142;
  localparam int          TOL      = 64;

  initial begin
    int edges;
    int ndone;
    int first;

    rst_n = 1'b0;
    start = 1'b0;
    angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_theta", theta, 32'd0);
    check("reset_range_err", {31'd0, range_err}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // angle 0: cos = 1.0
    run(F_ZERO, edges);
    check("zero_latency", edges, 32'd33);
    check_near("zero_result", result, Q_ONE, TOL);
    check_near("zero_theta", theta, 32'd0, TOL);
    check("zero_range_err", {31'd0, range_err}, 32'd0);
    @(posedge clk);
    #1;
    check("zero_done_one_cycle", {31'd0, done}, 32'd0);
    check("zero_busy_clear", {31'd0, busy}, 32'd0);

    // +pi/3 and -pi/3: cos = 0.5, theta follows the sign of the input
    run(F_PI3, edges);
    check("pi3_latency", edges, 32'd33);
    check_near("pi3_result", result, Q_HALF, TOL);
    check_near("pi3_theta", theta, Q_PI3, TOL);
    check("pi3_theta_sign", {31'd0, theta[31]}, 32'd0);

    run(F_NPI3, edges);
    check_near("npi3_result", result, Q_HALF, TOL);
    check_near("npi3_theta", theta, Q_NPI3, TOL);
    check("npi3_theta_sign", {31'd0, theta[31]}, 32'd1);

    // 0.5 rad
    run(F_HALF, edges);
    check("half_latency", edges, 32'd33);
    check_near("half_theta", theta, Q_HALF, TOL);
    check_near("half_result", result, Q_COS05, TOL);
    repeat (5) @(posedge clk);
    #1;
    check_near("half_result_held", result, Q_COS05, TOL);

    // Out-of-range inputs: done on the next edge, with zeroed outputs
    run(F_2P5, edges);
    check("big_latency", edges, 32'd1);
    check("big_range_err", {31'd0, range_err}, 32'd1);
    check("big_result", result, 32'd0);
    check("big_theta", theta, 32'd0);
    @(posedge clk);
    #1;
    check("big_done_one_cycle", {31'd0, done}, 32'd0);

    run(F_NAN, edges);
    check("nan_latency", edges, 32'd1);
    check("nan_range_err", {31'd0, range_err}, 32'd1);
    check("nan_result", result, 32'd0);

    run(F_NEG2, edges);
    check("neg2_range_err", {31'd0, range_err}, 32'd1);

    // Valid inputs clear range_err. A denormal unpacks to zero.
    run(F_DENORM, edges);
    check("denorm_latency", edges, 32'd33);
    check("denorm_range_err", {31'd0, range_err}, 32'd0);
    check_near("denorm_result", result, Q_ONE, TOL);

    run(F_BELOW2, edges);
    check("below2_latency", edges, 32'd33);
    check("below2_range_err", {31'd0, range_err}, 32'd0);

    // A start pulse at cycle 10 of a busy run must be ignored
    @(negedge clk);
    angle = F_HALF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start = (n == 10);
      angle = (n == 10) ? F_NAN : F_HALF;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) first = n;
      end
    end
    start = 1'b0;
    check("busy_start_done_count", ndone, 32'd1);
    check("busy_start_latency", first, 32'd33);
    check("busy_start_range_err", {31'd0, range_err}, 32'd0);
    check_near("busy_start_theta", theta, Q_HALF, TOL);

    // Reset during iteration 15: the outputs clear at once and no done follows
    @(negedge clk);
    angle = F_PI3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_theta", theta, 32'd0);
    check("abort_range_err", {31'd0, range_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);

    // Start must be accepted on the first edge after rst_n rises
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    angle = F_ZERO;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("post_reset_busy", {31'd0, busy}, 32'd1);
    edges = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = n;
        break;
      end
    end
    check("post_reset_latency", edges, 32'd33);
    check_near("post_reset_result", result, Q_ONE, TOL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
